// File: rtl/wvb_storage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wvb_storage_pkg
//  Description : Shared defaults for the waveform buffer storage slice:
//                sample word / RAM address widths, header FIFO geometry and
//                almost-full threshold, plus the sticky error-flag record.
//                Reused by the waveform buffer writer and reader blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package wvb_storage_pkg;

    localparam int c_WVB_DATA_WIDTH   = 28;    // bit 0 carries end-of-event
    localparam int c_WVB_ADR_WIDTH    = 15;    // waveform RAM depth 2^15
    localparam int c_HDR_WIDTH        = 87;
    localparam int c_HDR_DEPTH_WIDTH  = 10;    // header FIFO depth 2^10
    localparam int c_HDR_AFULL_THRESH = 1000;

    // Sticky header FIFO error flags, held until err_clr.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } hdr_err_t;

endpackage : wvb_storage_pkg
`default_nettype wire

// File: rtl/waveform_buffer_storage_v2_hdr_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : hdr_fifo_sync
//  Description : Single-clock standard (non-FWFT) header FIFO with exact
//                occupancy count, registered flags and sticky errors.
//  Ports       : clk, rst_n        clock / synchronous active-low reset
//                wr_req_i/wr_data_i push request and word
//                rd_req_i/rd_data_o pop request, popped word (held)
//                full_o/empty_o/almost_full_o  registered flags
//                count_o           occupancy 0..2^P_DEPTH_WIDTH
//                overflow_o/underflow_o sticky errors, err_clr_i clears
//  Revision    : 1.0 - initial release
// ============================================================================
module hdr_fifo_sync
    import wvb_storage_pkg::*;
#(
    parameter int P_WIDTH        = c_HDR_WIDTH,
    parameter int P_DEPTH_WIDTH  = c_HDR_DEPTH_WIDTH,
    parameter int P_AFULL_THRESH = c_HDR_AFULL_THRESH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_req_i,
    input  logic [P_WIDTH-1:0]       wr_data_i,
    input  logic                     rd_req_i,
    output logic [P_WIDTH-1:0]       rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic [P_DEPTH_WIDTH:0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    input  logic                     err_clr_i
);

    localparam int                   c_DEPTH     = 1 << P_DEPTH_WIDTH;
    localparam logic [P_DEPTH_WIDTH:0] c_DEPTH_CNT = (P_DEPTH_WIDTH+1)'(c_DEPTH);
    localparam logic [P_DEPTH_WIDTH:0] c_AFULL_CNT = (P_DEPTH_WIDTH+1)'(P_AFULL_THRESH);
    localparam logic [P_DEPTH_WIDTH:0] c_ONE       = (P_DEPTH_WIDTH+1)'(1);

    logic [P_WIDTH-1:0]       mem [0:c_DEPTH-1];

    logic [P_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_DEPTH_WIDTH:0]   count_q,  count_d;
    logic [P_WIDTH-1:0]       data_q,   data_d;
    logic                     full_q,   full_d;
    logic                     empty_q,  empty_d;
    logic                     afull_q,  afull_d;
    hdr_err_t                 err_q,    err_d;

    // Acceptance uses this cycle's registered flags, so a push into a full
    // FIFO is dropped even when a pop frees a slot in the same cycle.
    logic w_push, w_pop;
    assign w_push = wr_req_i & ~full_q;
    assign w_pop  = rd_req_i & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;   // wraps modulo depth
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            data_d   = mem[rd_ptr_q];
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_ONE;
            2'b01:   count_d = count_q - c_ONE;
            default: count_d = count_q;
        endcase
        // Flags are derived from the next count so they are registered yet
        // always consistent with count_o.
        empty_d = (count_d == '0);
        full_d  = (count_d == c_DEPTH_CNT);
        afull_d = (count_d >= c_AFULL_CNT);
        // A fresh error in the clearing cycle takes priority over err_clr.
        err_d.overflow  = (err_q.overflow  & ~err_clr_i) | (wr_req_i & full_q);
        err_d.underflow = (err_q.underflow & ~err_clr_i) | (rd_req_i & empty_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            err_q    <= err_d;
        end
    end

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) mem[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o     = data_q;
    assign full_o        = full_q;
    assign empty_o       = empty_q;
    assign almost_full_o = afull_q;
    assign count_o       = count_q;
    assign overflow_o    = err_q.overflow;
    assign underflow_o   = err_q.underflow;

endmodule : hdr_fifo_sync
`default_nettype wire

// File: rtl/waveform_buffer_storage_v2.sv
`default_nettype none
// ============================================================================
//  Module      : waveform_buffer_storage_v2
//  Description : Waveform sample RAM (write strobe, free-running registered
//                read, read-before-write) plus the event header FIFO.
//  Ports       : clk, rst_n                 clock / sync active-low reset
//                eoe_in, wvb_data_in         sample word, bit 0 <- eoe_in
//                wvb_wr_addr, wvb_wrreq      RAM write
//                wvb_rd_addr, wvb_data_out   RAM read, one-cycle latency
//                hdr_data_in, hdr_wrreq      header push
//                hdr_rdreq, hdr_data_out     header pop (standard FIFO)
//                hdr_full/empty/almost_full  registered flags
//                n_wvf_in_buf                exact header count
//                hdr_overflow/underflow      sticky errors, err_clr clears
//  Revision    : 1.0 - initial release
// ============================================================================
module waveform_buffer_storage_v2
    import wvb_storage_pkg::*;
#(
    parameter int P_DATA_WIDTH      = c_WVB_DATA_WIDTH,
    parameter int P_ADR_WIDTH       = c_WVB_ADR_WIDTH,
    parameter int P_HDR_WIDTH       = c_HDR_WIDTH,
    parameter int P_HDR_DEPTH_WIDTH = c_HDR_DEPTH_WIDTH,
    parameter int P_AFULL_THRESH    = c_HDR_AFULL_THRESH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         eoe_in,
    input  logic [P_DATA_WIDTH-1:0]      wvb_data_in,
    input  logic [P_ADR_WIDTH-1:0]       wvb_wr_addr,
    input  logic                         wvb_wrreq,
    input  logic [P_ADR_WIDTH-1:0]       wvb_rd_addr,
    output logic [P_DATA_WIDTH-1:0]      wvb_data_out,
    input  logic [P_HDR_WIDTH-1:0]       hdr_data_in,
    input  logic                         hdr_wrreq,
    input  logic                         hdr_rdreq,
    output logic [P_HDR_WIDTH-1:0]       hdr_data_out,
    output logic                         hdr_full,
    output logic                         hdr_empty,
    output logic                         hdr_almost_full,
    output logic [P_HDR_DEPTH_WIDTH:0]   n_wvf_in_buf,
    output logic                         hdr_overflow,
    output logic                         hdr_underflow,
    input  logic                         err_clr
);

    localparam int c_WVB_DEPTH = 1 << P_ADR_WIDTH;

    logic [P_DATA_WIDTH-1:0] wvb_mem [0:c_WVB_DEPTH-1];
    logic [P_DATA_WIDTH-1:0] wvb_rd_q;
    logic [P_DATA_WIDTH-1:0] wvb_wr_word_d;

    // Bit 0 of the stored word is the end-of-event marker, not sample data.
    assign wvb_wr_word_d = {wvb_data_in[P_DATA_WIDTH-1:1], eoe_in};

    always_ff @(posedge clk) begin
        if (wvb_wrreq) wvb_mem[wvb_wr_addr] <= wvb_wr_word_d;
    end

    // Non-blocking read of the array gives old data on a same-address
    // read/write collision.
    always_ff @(posedge clk) begin
        if (!rst_n) wvb_rd_q <= '0;
        else        wvb_rd_q <= wvb_mem[wvb_rd_addr];
    end

    assign wvb_data_out = wvb_rd_q;

    hdr_fifo_sync #(
        .P_WIDTH        (P_HDR_WIDTH),
        .P_DEPTH_WIDTH  (P_HDR_DEPTH_WIDTH),
        .P_AFULL_THRESH (P_AFULL_THRESH)
    ) u_hdr_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_req_i      (hdr_wrreq),
        .wr_data_i     (hdr_data_in),
        .rd_req_i      (hdr_rdreq),
        .rd_data_o     (hdr_data_out),
        .full_o        (hdr_full),
        .empty_o       (hdr_empty),
        .almost_full_o (hdr_almost_full),
        .count_o       (n_wvf_in_buf),
        .overflow_o    (hdr_overflow),
        .underflow_o   (hdr_underflow),
        .err_clr_i     (err_clr)
    );

endmodule : waveform_buffer_storage_v2
`default_nettype wire
